// File: rtl/fc_pkg.sv
// Shared types and helpers for the gray-coded frequency counter path.
// Gray-to-binary conversion handles widths up to FC_MAX_W bits.
package fc_pkg;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_PRIME,
    FC_RUN
  } fc_state_t;

  localparam int FC_MAX_W       = 64;
  localparam int FC_DATA_WIDTH  = 32;
  localparam int FC_GATE_CYCLES = 100_000_000;
  localparam int FC_MAX_STEP    = 4;

  // Running XOR from the MSB down; bits at or above w come out zero.
  function automatic logic [FC_MAX_W-1:0] gray2bin(
    input logic [FC_MAX_W-1:0] g,
    input int                  w
  );
    logic [FC_MAX_W-1:0] b;
    logic                acc;
    b   = '0;
    acc = 1'b0;
    for (int i = FC_MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_freq_decoder_if.sv
// Measurement bus between readout logic (master) and the decoder (slave).
// The master drives enable and the gray count; the slave returns results.
interface gray_freq_decoder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] gray;
  logic [DATA_WIDTH-1:0] count;
  logic                  valid;
  logic                  busy;
  logic                  step_err;

  modport master (
    output enable, gray,
    input  count, valid, busy, step_err
  );

  modport slave (
    input  enable, gray,
    output count, valid, busy, step_err
  );
endinterface

// File: rtl/fc_gate_timer.sv
// Gate window counter 0..GATE_CYCLES-1 with synchronous clear.
// tc_o flags the last reference cycle of a window.
module fc_gate_timer #(
  parameter int GATE_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int CW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(GATE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gray_freq_decoder.sv
// Decodes a resynchronised gray count and reports source edges per gate window.
// Define FC_STEP_CHECK_EN to add the sticky implausible-step detector.
module gray_freq_decoder
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = FC_DATA_WIDTH,
  parameter int GATE_CYCLES = FC_GATE_CYCLES,
  parameter int MAX_STEP    = FC_MAX_STEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] gray_i,
  output logic [DATA_WIDTH-1:0] count_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  step_err_o
);

  fc_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  busy;
  logic                  tc;
  logic                  tmr_clr;

  assign busy    = (state_q != FC_IDLE);
  assign tmr_clr = !enable_i || !busy;

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign busy_o  = busy;

  fc_gate_timer #(
    .GATE_CYCLES(GATE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run_i (busy),
    .clr_i (tmr_clr),
    .tc_o  (tc)
  );

  always_comb begin
    bin_d = DATA_WIDTH'(gray2bin(FC_MAX_W'(gray_i), DATA_WIDTH));
  end

  // A terminal-cycle update completes even if enable falls that cycle.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    valid_d = 1'b0;
    unique case (state_q)
      FC_IDLE: begin
        if (enable_i) state_d = FC_PRIME;
      end
      FC_PRIME: begin
        if (tc) begin
          base_d  = bin_q;
          state_d = FC_RUN;
        end
      end
      FC_RUN: begin
        if (tc) begin
          count_d = bin_q - base_q;
          base_d  = bin_q;
          valid_d = 1'b1;
        end
      end
      default: state_d = FC_IDLE;
    endcase
    if (!enable_i) state_d = FC_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FC_IDLE;
      bin_q   <= '0;
      base_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      base_q  <= base_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

`ifdef FC_STEP_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] STEP_LIM = DATA_WIDTH'(MAX_STEP);

  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] step;
  logic                  busy_prev_q, busy_prev_d;
  logic                  err_q, err_d;

  // prev is stale on the first busy cycle, so that cycle is not judged.
  always_comb begin
    prev_d      = bin_q;
    busy_prev_d = busy;
    step        = bin_q - prev_q;
    err_d       = err_q;
    if (!enable_i) begin
      err_d = 1'b0;
    end else if (busy && busy_prev_q && (step > STEP_LIM)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      busy_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      busy_prev_q <= busy_prev_d;
      err_q       <= err_d;
    end
  end

  assign step_err_o = err_q;
`else
  assign step_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_freq_decoder.sv
// Scenario bench for gray_freq_decoder (DATA_WIDTH=8, GATE_CYCLES=10).
// Expected window counts are queued as stimulus is chosen and popped on valid_o.
module tb_gray_freq_decoder;
  localparam int DW = 8;
  localparam int GC = 10;
  localparam int MS = 4;
`ifdef FC_STEP_CHECK_EN
  localparam logic SC = 1'b1;
`else
  localparam logic SC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_freq_decoder_if #(.DATA_WIDTH(DW)) bus ();

  gray_freq_decoder #(
    .DATA_WIDTH  (DW),
    .GATE_CYCLES (GC),
    .MAX_STEP    (MS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (bus.enable),
    .gray_i     (bus.gray),
    .count_o    (bus.count),
    .valid_o    (bus.valid),
    .busy_o     (bus.busy),
    .step_err_o (bus.step_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] src = '0;
  int step = 1;

  function automatic logic [DW-1:0] b2g(input logic [DW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    src = src + DW'(step);
    bus.gray = b2g(src);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus.count, bus.valid, bus.busy, bus.step_err} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got count=%0d v=%b b=%b e=%b want all 0",
                 bus.count, bus.valid, bus.busy, bus.step_err);
      end
      src = DW'($urandom);
      bus.gray = b2g(src);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic go_idle();
    bus.enable = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy: got %b want 0", bus.busy);
    end
    adv();
  endtask

  task automatic test_steady();
    int nv;
    nv = 21;
    src = '0;
    step = 1;
    bus.gray = b2g(src);
    bus.enable = 1'b1;
    repeat (3) exp_q.push_back(DW'(GC));
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 1) begin
        n_cmp++;
        if (bus.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL steady_busy: got %b want 1", bus.busy);
        end
      end
      if (bus.valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL steady_extra_valid: got valid at clk %0d want none", c);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.count !== exp_v) begin
            n_bad++;
            $display("FAIL steady_count: got %0d want %0d", bus.count, exp_v);
          end
        end
        n_cmp++;
        if (c != nv) begin
          n_bad++;
          $display("FAIL steady_timing: got clk %0d want clk %0d", c, nv);
        end
        nv += GC;
      end
      adv();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL steady_missing: got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    src = 8'd209;
    step = 3;
    bus.gray = b2g(src);
    bus.enable = 1'b1;
    repeat (2) exp_q.push_back(8'h1E);
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (bus.valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL wrap_extra_valid: got valid at clk %0d want none", c);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.count !== exp_v) begin
            n_bad++;
            $display("FAIL wrap_count: got %0d want %0d", bus.count, exp_v);
          end
        end
      end
      adv();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_missing: got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_enable_drop();
    src = '0;
    step = 1;
    bus.gray = b2g(src);
    bus.enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL drop_early_valid: got valid at clk %0d want none", c);
      end
      if (c != 16) adv();
    end
    bus.enable = 1'b0;
    adv();
    tick();
    n_cmp++;
    if ({bus.busy, bus.valid} !== 2'b00 || bus.count !== 8'h1E) begin
      n_bad++;
      $display("FAIL drop_state: got b=%b v=%b count=%0d want b=0 v=0 count=30",
               bus.busy, bus.valid, bus.count);
    end
    adv();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (bus.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL drop_idle_valid: got valid at idle clk %0d want none", c);
      end
      adv();
    end
    bus.enable = 1'b1;
    exp_q.push_back(DW'(GC));
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (bus.valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL reenable_extra_valid: got valid at clk %0d want none", c);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.count !== exp_v || c != 21) begin
            n_bad++;
            $display("FAIL reenable_count: got %0d at clk %0d want %0d at clk 21",
                     bus.count, c, exp_v);
          end
        end
      end
      adv();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reenable_missing: got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    bus.enable = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      adv();
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.count, bus.valid, bus.busy, bus.step_err} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got count=%0d v=%b b=%b e=%b want all 0",
               bus.count, bus.valid, bus.busy, bus.step_err);
    end
    bus.enable = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_cmp++;
      if ({bus.valid, bus.busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL async_after: got v=%b b=%b at clk %0d want 0 0",
                 bus.valid, bus.busy, c);
      end
      adv();
    end
  endtask

  task automatic test_step_check();
    src = 8'd5;
    step = 0;
    bus.gray = b2g(src);
    bus.enable = 1'b1;
    exp_q.push_back(8'd15);
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (bus.valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL step_extra_valid: got valid at clk %0d want none", c);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.count !== exp_v) begin
            n_bad++;
            $display("FAIL step_count: got %0d want %0d", bus.count, exp_v);
          end
        end
      end
      if (c == 13) begin
        n_cmp++;
        if (bus.step_err !== 1'b0) begin
          n_bad++;
          $display("FAIL step_err_early: got %b want 0", bus.step_err);
        end
      end
      if (c == 14 || c == 26) begin
        n_cmp++;
        if (bus.step_err !== SC) begin
          n_bad++;
          $display("FAIL step_err_set: got %b want %b at clk %0d", bus.step_err, SC, c);
        end
      end
      adv();
      if (c == 12) begin
        src = 8'd20;
        bus.gray = b2g(src);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL step_missing: got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
    bus.enable = 1'b0;
    tick();
    n_cmp++;
    if ({bus.step_err, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL step_err_clear: got e=%b b=%b want 0 0", bus.step_err, bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    bus.enable = 1'b0;
    bus.gray = '0;
    test_reset();
    test_steady();
    go_idle();
    test_wrap();
    go_idle();
    test_enable_drop();
    test_async_reset();
    test_step_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
